// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the fetch and data requesters, one access at a time.
// Optional: define ARB_RR_EN for alternating grants on simultaneous requests (default: data wins).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] LatLoad = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              owner_q;  // 1 = data requester, 0 = fetch
  logic              grant, grant_data;
  logic              mem_en_q, mem_we_q, mem_byte_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_done_q, d_done_q;

`ifdef ARB_RR_EN
  logic last_grant_q;  // 1 = data was granted last

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b0;
    end else if (grant) begin
      last_grant_q <= grant_data;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          state_d    = StAccess;
          grant      = 1'b1;
          grant_data = d_req;
`ifdef ARB_RR_EN
          if (if_req && d_req) begin
            grant_data = ~last_grant_q;
          end
`endif
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if (grant) begin
        owner_q     <= grant_data;
        cnt_q       <= LatLoad;
        mem_en_q    <= 1'b1;
        mem_we_q    <= grant_data & d_we;
        mem_byte_q  <= grant_data & d_byte;
        mem_addr_q  <= grant_data ? d_addr : if_addr;
        mem_wdata_q <= grant_data ? d_wdata : '0;
      end else if (state_q == StAccess) begin
        if (cnt_q == 4'd0) begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (owner_q) begin
            d_done_q <= 1'b1;
            // Writes leave the data read register untouched.
            if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end else begin
            if_done_q  <= 1'b1;
            if_rdata_q <= mem_rdata;
          end
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign busy      = (state_q != StIdle);

endmodule
